ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)
//  to the keyboard on the shared PS2_CLK/PS2_DAT lines. Drives lines open-drain via

---
 rtl/ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs,
// 0xFF reset) to the keyboard over the shared PS2_CLK/PS2_DAT lines. The lines
// are driven open-drain through active-high pull-low enables; the keyboard
// receiver next to this block keeps its own view of the raw pins.
//
// Frame on the wire: start(0), 8 data bits LSB first, odd parity, stop(1),
// then the device ACK bit. The host inhibits the bus by holding PS2_CLK low,
// asserts the start bit, releases the clock and then changes data only in the
// cycle after a detected falling edge of the (synchronized) device clock.
//
// Parameters
//   INHIBIT_CYCLES  clk50 cycles PS2_CLK is held low before release (>= 2)
//   START_TIMEOUT   max cycles from clock release to the first device fall
//   FRAME_TIMEOUT   max cycles from the first device fall to bus idle
//
// Build option
//   PS2_TX_ACK_CHECK_EN  when defined, the ACK bit sampled at fall 11 must be
//                        0, otherwise tx_error pulses instead of tx_done. When
//                        undefined, fall 11 is still awaited but its data
//                        value is ignored.
//
// Ports
//   clk50       in   system clock, 50 MHz
//   reset_kb    in   asynchronous reset, active-low
//   tx_data     in   [7:0] command byte, captured when tx_start is accepted
//   tx_start    in   transmit request, accepted only while tx_busy = 0
//   tx_busy     out  high from the accept cycle through the done/error pulse
//   tx_done     out  one-cycle pulse: frame sent (and ACKed when checked)
//   tx_error    out  one-cycle pulse: timeout or missing ACK
//   ps2_clk_in  in   raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pin level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  out  1 = pull PS2_DAT low, 0 = release
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int FRAME_TIMEOUT  = 100000
) (
    input  logic       clk50,
    input  logic       reset_kb,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One counter serves both the inhibit interval and the start timeout.
    localparam int CNT_MAX_C = (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
    localparam int CNT_W_C   = $clog2(CNT_MAX_C + 2);
    localparam int FRM_W_C   = $clog2(FRAME_TIMEOUT + 2);

    localparam logic [CNT_W_C-1:0] CNT_ONE_C  = {{(CNT_W_C-1){1'b0}}, 1'b1};
    localparam logic [CNT_W_C-1:0] CNT_SAT_C  = {CNT_W_C{1'b1}};
    localparam logic [CNT_W_C-1:0] INH_DAT_C  = CNT_W_C'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W_C-1:0] INH_END_C  = CNT_W_C'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W_C-1:0] START_TO_C = CNT_W_C'(START_TIMEOUT);
    localparam logic [FRM_W_C-1:0] FRM_ONE_C  = {{(FRM_W_C-1){1'b0}}, 1'b1};
    localparam logic [FRM_W_C-1:0] FRM_SAT_C  = {FRM_W_C{1'b1}};
    localparam logic [FRM_W_C-1:0] FRAME_TO_C = FRM_W_C'(FRAME_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } state_t;

    // Odd parity bit: makes the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    state_t               state_r;
    logic [9:0]           shift_r;
    logic [CNT_W_C-1:0]   cnt_r;
    logic [FRM_W_C-1:0]   frm_r;
    logic [3:0]           bit_idx_r;

    logic clk_meta_r, clk_sync_r, clk_prev_r;
    logic dat_meta_r, dat_sync_r;
    logic fall_s;

    // Two-flop synchronizers for the raw pins plus previous-clock history.
    // Idle bus level is high, so reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge clk50 or negedge reset_kb) begin
        if (!reset_kb) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r;

    // Transmit sequencer: owns all outputs, the shift register and timers.
    always_ff @(posedge clk50 or negedge reset_kb) begin
        if (!reset_kb) begin
            state_r    <= ST_IDLE;
            shift_r    <= 10'd0;
            cnt_r      <= '0;
            frm_r      <= '0;
            bit_idx_r  <= 4'd0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            // Pulses are high only in the cycle after they are set.
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_start) begin
                        shift_r    <= {1'b1, odd_parity(tx_data), tx_data};
                        cnt_r      <= '0;
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state_r    <= ST_INHIBIT;
                    end else begin
                        tx_busy <= 1'b0;
                    end
                end

                // Clock held low; start bit goes out one cycle before release.
                ST_INHIBIT: begin
                    if (cnt_r >= INH_END_C) begin
                        ps2_dat_oe <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_REQ;
                    end else begin
                        if (cnt_r == INH_DAT_C) begin
                            ps2_dat_oe <= 1'b1;
                        end else begin
                            ps2_dat_oe <= ps2_dat_oe;
                        end
                        cnt_r <= cnt_r + CNT_ONE_C;
                    end
                end

                // Waiting for the device to start clocking; fall 1 sends bit 0.
                ST_REQ: begin
                    if (cnt_r > START_TO_C) begin
                        tx_error   <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state_r    <= ST_ERR;
                    end else if (fall_s) begin
                        ps2_dat_oe <= ~shift_r[0];
                        shift_r    <= {1'b0, shift_r[9:1]};
                        bit_idx_r  <= 4'd0;
                        frm_r      <= '0;
                        state_r    <= ST_SHIFT;
                    end else begin
                        cnt_r <= (cnt_r == CNT_SAT_C) ? cnt_r : cnt_r + CNT_ONE_C;
                    end
                end

                // Falls 2..10 drive bits 1..9; the stop bit (1) releases data.
                ST_SHIFT: begin
                    if (frm_r > FRAME_TO_C) begin
                        tx_error   <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state_r    <= ST_ERR;
                    end else begin
                        frm_r <= (frm_r == FRM_SAT_C) ? frm_r : frm_r + FRM_ONE_C;
                        if (fall_s) begin
                            ps2_dat_oe <= ~shift_r[0];
                            shift_r    <= {1'b0, shift_r[9:1]};
                            bit_idx_r  <= bit_idx_r + 4'd1;
                            if (bit_idx_r == 4'd8) begin
                                state_r <= ST_ACK;
                            end else begin
                                state_r <= ST_SHIFT;
                            end
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                end

                // Fall 11 carries the device ACK on the data line.
                ST_ACK: begin
                    if (frm_r > FRAME_TO_C) begin
                        tx_error   <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state_r    <= ST_ERR;
                    end else begin
                        frm_r <= (frm_r == FRM_SAT_C) ? frm_r : frm_r + FRM_ONE_C;
                        if (fall_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            if (dat_sync_r) begin
                                tx_error   <= 1'b1;
                                ps2_clk_oe <= 1'b0;
                                ps2_dat_oe <= 1'b0;
                                state_r    <= ST_ERR;
                            end else begin
                                state_r <= ST_WAIT_IDLE;
                            end
`else
                            state_r <= ST_WAIT_IDLE;
`endif
                        end else begin
                            state_r <= ST_ACK;
                        end
                    end
                end

                // Device must let both lines float high before we report done.
                ST_WAIT_IDLE: begin
                    if (frm_r > FRAME_TO_C) begin
                        tx_error   <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state_r    <= ST_ERR;
                    end else if (clk_sync_r && dat_sync_r) begin
                        tx_done <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        frm_r <= (frm_r == FRM_SAT_C) ? frm_r : frm_r + FRM_ONE_C;
                    end
                end

                // Pulse cycle: busy still high here, so tx_start is ignored.
                ST_DONE: begin
                    tx_busy <= 1'b0;
                    state_r <= ST_IDLE;
                end

                ST_ERR: begin
                    tx_busy    <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    tx_busy    <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Self-checking bench for ps2_host_tx. A behavioural keyboard model clocks the
// bus, samples what the host puts on PS2_DAT and optionally ACKs. Expected
// frames are built from the byte value (LSB-first data, odd parity from a
// ones count, stop = 1). Timeouts are shortened through the parameters.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int STO = 2000;
    localparam int FTO = 1500;
    localparam int H   = 15;     // device clock half period in clk50 cycles

    logic       clk50 = 1'b0;
    logic       reset_kb = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;
    int err_total = 0;
    int bad_pulse = 0;
    int viol = 0;
    int cyc = 0;
    int t_fall1 = 0;
    bit mon_en = 1'b0;
    logic prev_dat_oe = 1'b0;

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .FRAME_TIMEOUT (FTO)
    ) dut (
        .clk50     (clk50),
        .reset_kb  (reset_kb),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    // Pulse counting, busy-during-pulse, and data-change-while-clock-high watch.
    always @(negedge clk50) begin
        if (tx_done)  done_total <= done_total + 1;
        if (tx_error) err_total  <= err_total + 1;
        if ((tx_done || tx_error) && !tx_busy) bad_pulse <= bad_pulse + 1;
        if (mon_en && (ps2_dat_oe !== prev_dat_oe) && ps2_clk_in) viol <= viol + 1;
        prev_dat_oe <= ps2_dat_oe;
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame as seen on PS2_DAT after falls 1..10.
    function automatic logic [9:0] frame_bits(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("busy after accept", tx_busy, 1);
    endtask

    task automatic inhibit_phase(input string tag);
        int c;
        c = 0;
        while (ps2_clk_oe === 1'b1 && c < 4 * INH) begin
            c++;
            tick();
        end
        check({tag, " inhibit len"}, c, INH);
        check({tag, " start bit"}, ps2_dat_oe, 1);
    endtask

    // Keyboard model: n falls; ACK on fall 11 if requested; optional
    // tx_start poke with a different byte while the frame is in progress.
    task automatic dev_falls(input int n, input bit ack, input bit poke, output logic [9:0] bits);
        bits = 10'd0;
        for (int k = 1; k <= n; k++) begin
            repeat (H / 2) tick();
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (H - H / 2) tick();
            dev_clk_low = 1'b1;
            if (k == 1) t_fall1 = cyc;
            if (k == 3 && poke) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
            repeat (H) tick();
            if (k <= 10) bits[k-1] = ps2_dat_in;
            dev_clk_low = 1'b0;
        end
        repeat (H) tick();
        dev_dat_low = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] d, input bit ack, input bit poke, input string tag);
        logic [9:0] bits;
        int d0, e0, c, exp_done;
        d0 = done_total;
        e0 = err_total;
`ifdef PS2_TX_ACK_CHECK_EN
        exp_done = ack ? 1 : 0;
`else
        exp_done = 1;
`endif
        start_tx(d);
        inhibit_phase(tag);
        dev_falls(11, ack, poke, bits);
        check({tag, " bits"}, {22'd0, bits}, {22'd0, frame_bits(d)});
        c = 0;
        while (!tx_done && !tx_error && tx_busy && c < 400) begin
            c++;
            tick();
        end
        if (poke && tx_done) begin
            tx_data  = 8'hA5;
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
            repeat (3) tick();
            check({tag, " start in done ignored"}, {ps2_clk_oe, tx_busy}, 2'b00);
        end
        c = 0;
        while (tx_busy && c < 400) begin
            c++;
            tick();
        end
        check({tag, " busy end"}, tx_busy, 0);
        repeat (5) tick();
        check({tag, " done count"}, done_total - d0, exp_done);
        check({tag, " error count"}, err_total - e0, 1 - exp_done);
        check({tag, " lines released"}, {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    endtask

    initial begin
        int c, d0, e0;
        logic [9:0] bits;

        // Reset state
        #5;
        check("reset outputs", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 5'b00000);
        repeat (3) tick();
        reset_kb = 1'b1;
        repeat (3) tick();
        check("idle outputs", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 5'b00000);
        mon_en = 1'b1;

        // Directed bytes, with busy / done-cycle tx_start pokes on 0xED
        do_frame(8'hED, 1'b1, 1'b1, "ED");
        do_frame(8'hFF, 1'b1, 1'b0, "FF");
        do_frame(8'h00, 1'b1, 1'b0, "00");
        for (int i = 0; i < 5; i++) begin
            do_frame(8'($urandom), 1'b1, 1'b0, "rand");
        end

        // Missing ACK
        do_frame(8'($urandom), 1'b0, 1'b0, "noack");

        // No device clock after release -> start timeout
        mon_en = 1'b0;
        d0 = done_total;
        e0 = err_total;
        start_tx(8'h12);
        inhibit_phase("sto");
        c = 0;
        while (!tx_error && c < STO + 100) begin
            c++;
            tick();
        end
        check("sto latency window", (c >= STO && c <= STO + 4), 1);
        check("sto lines at error", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        repeat (3) tick();
        check("sto busy", tx_busy, 0);
        check("sto counts", {done_total - d0, err_total - e0}, {32'd0, 32'd1});

        // Device stops after 5 falls -> frame timeout
        d0 = done_total;
        e0 = err_total;
        start_tx(8'hC6);
        inhibit_phase("fto");
        dev_falls(5, 1'b0, 1'b0, bits);
        c = 0;
        while (!tx_error && c < FTO + 200) begin
            c++;
            tick();
        end
        check("fto latency window", ((cyc - t_fall1) >= FTO && (cyc - t_fall1) <= FTO + 10), 1);
        check("fto lines at error", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        repeat (3) tick();
        check("fto counts", {done_total - d0, err_total - e0}, {32'd0, 32'd1});

        // Reset after fall 4 while device holds clock low
        d0 = done_total;
        e0 = err_total;
        start_tx(8'hC3);
        inhibit_phase("rst");
        dev_falls(3, 1'b0, 1'b0, bits);
        repeat (H) tick();
        dev_clk_low = 1'b1;
        repeat (H) tick();
        reset_kb = 1'b0;
        #1;
        check("rst same-cycle outputs", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
        dev_clk_low = 1'b0;
        repeat (3) tick();
        reset_kb = 1'b1;
        repeat (30) tick();
        check("rst no pulses", {done_total - d0, err_total - e0}, {32'd0, 32'd0});
        check("rst idle", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);

        // Recovery after reset
        mon_en = 1'b1;
        do_frame(8'($urandom), 1'b1, 1'b0, "post-rst");

        check("data changed while clock high", viol, 0);
        check("pulse without busy", bad_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
